// File: rtl/sid_pkg.sv
// rtl/sid_pkg.sv - shared SID register addresses, mixer FSM states and output clipper
package sid_pkg;

  localparam logic [4:0] ADDR_RES_FILT = 5'h17;
  localparam logic [4:0] ADDR_MODE_VOL = 5'h18;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    MIX,
    VOL,
    OUT
  } sidMixState_t;

  // Saturate a wide signed value into the 16-bit sample range.
  function automatic logic [15:0] clip16(input logic signed [23:0] x);
    if (x > 24'sd32767) begin
      return 16'h7fff;
    end else if (x < -24'sd32768) begin
      return 16'h8000;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/sid_mixer_vol.sv
// rtl/sid_mixer_vol.sv - 4-cycle shift-add master volume multiplier
module sid_mixer_vol (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [18:0] mix,
  input  logic [3:0]  vol,
  output logic [22:0] acc,
  output logic        done
);

  logic [18:0] mixReg;
  logic [3:0]  volReg;
  logic [1:0]  bitCnt;
  logic        busy;
  logic [22:0] partial;

  // Current partial product: sign-extended mix shifted by the volume bit index.
  assign partial = {{4{mixReg[18]}}, mixReg} << bitCnt;

  // Done is raised during the last iteration so the caller can step on the same edge.
  assign done = busy && (bitCnt == 2'd3);

  // Latch operands on start, then add one weighted partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mixReg <= '0;
      volReg <= '0;
      bitCnt <= '0;
      busy   <= 1'b0;
      acc    <= '0;
    end else if (start) begin
      mixReg <= mix;
      volReg <= vol;
      bitCnt <= '0;
      busy   <= 1'b1;
      acc    <= '0;
    end else if (busy) begin
      if (volReg[bitCnt]) begin
        acc <= acc + partial;
      end
      bitCnt <= bitCnt + 2'd1;
      if (bitCnt == 2'd3) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sid_mixer.sv
// rtl/sid_mixer.sv - SID voice/filter router and master volume mixer (option: MIXER_DIGI_EN)
module sid_mixer
  import sid_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [15:0] iVoice0,
  input  logic [15:0] iVoice1,
  input  logic [15:0] iVoice2,
  input  logic [15:0] iLP,
  input  logic [15:0] iBP,
  input  logic [15:0] iHP,
  input  logic        iWE,
  input  logic [4:0]  iAddr,
  input  logic [7:0]  iData,
  output logic [15:0] oFiltIn,
  output logic [15:0] oOut,
  output logic        oValid
);

  logic [2:0]  regRoute;
  logic [3:0]  regVol;
  logic        regLP, regBP, regHP, reg3Off;

  logic [15:0] opV0, opV1, opV2, opLP, opBP, opHP;
  logic [2:0]  opRoute;
  logic [3:0]  opVol;
  logic        opLPEn, opBPEn, opHPEn, op3Off;

  sidMixState_t state;
  logic [17:0] dsum;
  logic [17:0] fsum, dsumNext;
  logic [18:0] mixVal;
  logic [22:0] acc;
  logic signed [22:0] accS;
  logic [22:0] shifted;
  logic [22:0] outPre;
  logic        volDone;
  logic        volStart;

  function automatic logic [17:0] ext18(input logic [15:0] v);
    return {{2{v[15]}}, v};
  endfunction

  function automatic logic [18:0] ext19(input logic [15:0] v);
    return {{3{v[15]}}, v};
  endfunction

  // Voice split: routed voices feed the filter, the rest bypass it; 3OFF only mutes an unrouted voice 2.
  always_comb begin
    fsum = (opRoute[0] ? ext18(opV0) : 18'd0)
         + (opRoute[1] ? ext18(opV1) : 18'd0)
         + (opRoute[2] ? ext18(opV2) : 18'd0);
    dsumNext = (!opRoute[0] ? ext18(opV0) : 18'd0)
             + (!opRoute[1] ? ext18(opV1) : 18'd0)
             + ((!opRoute[2] && !op3Off) ? ext18(opV2) : 18'd0);
  end

  // Direct path plus the mode-selected filter outputs.
  always_comb begin
    mixVal = {dsum[17], dsum}
           + (opLPEn ? ext19(opLP) : 19'd0)
           + (opBPEn ? ext19(opBP) : 19'd0)
           + (opHPEn ? ext19(opHP) : 19'd0);
  end

  assign accS    = acc;
  assign shifted = accS >>> 4;
  assign volStart = (state == MIX);

`ifdef MIXER_DIGI_EN
  // Volume register DC step, audible even with all voices silent.
  assign outPre = shifted + {10'd0, opVol, 9'd0};
`else
  assign outPre = shifted;
`endif

  sid_mixer_vol u_vol (
    .clk   (clk),
    .rst   (rst),
    .start (volStart),
    .mix   (mixVal),
    .vol   (opVol),
    .acc   (acc),
    .done  (volDone)
  );

  // Register decode for the routing and mode/volume registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      regRoute <= '0;
      regVol   <= '0;
      regLP    <= 1'b0;
      regBP    <= 1'b0;
      regHP    <= 1'b0;
      reg3Off  <= 1'b0;
    end else if (iWE) begin
      if (iAddr == ADDR_RES_FILT) begin
        regRoute <= iData[2:0];
      end else if (iAddr == ADDR_MODE_VOL) begin
        regVol  <= iData[3:0];
        regLP   <= iData[4];
        regBP   <= iData[5];
        regHP   <= iData[6];
        reg3Off <= iData[7];
      end
    end
  end

  // Sample sequencer: latch operands on clkEn, then SUM, MIX, VOL and OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      oFiltIn <= '0;
      oOut    <= '0;
      oValid  <= 1'b0;
      dsum    <= '0;
      opV0    <= '0;
      opV1    <= '0;
      opV2    <= '0;
      opLP    <= '0;
      opBP    <= '0;
      opHP    <= '0;
      opRoute <= '0;
      opVol   <= '0;
      opLPEn  <= 1'b0;
      opBPEn  <= 1'b0;
      opHPEn  <= 1'b0;
      op3Off  <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (clkEn) begin
            opV0    <= iVoice0;
            opV1    <= iVoice1;
            opV2    <= iVoice2;
            opLP    <= iLP;
            opBP    <= iBP;
            opHP    <= iHP;
            opRoute <= regRoute;
            opVol   <= regVol;
            opLPEn  <= regLP;
            opBPEn  <= regBP;
            opHPEn  <= regHP;
            op3Off  <= reg3Off;
            state   <= SUM;
          end
        end
        SUM: begin
          dsum    <= dsumNext;
          oFiltIn <= clip16({{6{fsum[17]}}, fsum});
          state   <= MIX;
        end
        MIX: state <= VOL;
        VOL: begin
          if (volDone) begin
            state <= OUT;
          end
        end
        OUT: begin
          oOut   <= clip16({outPre[22], outPre});
          oValid <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_mixer.sv
// tb/tb_sid_mixer.sv - scoreboard bench for sid_mixer
module tb_sid_mixer;

  logic        clk = 1'b0;
  logic        rst, clkEn, iWE;
  logic [15:0] iVoice0, iVoice1, iVoice2, iLP, iBP, iHP;
  logic [4:0]  iAddr;
  logic [7:0]  iData;
  logic [15:0] oFiltIn, oOut;
  logic        oValid;

  sid_mixer dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .iVoice0(iVoice0), .iVoice1(iVoice1), .iVoice2(iVoice2),
    .iLP(iLP), .iBP(iBP), .iHP(iHP),
    .iWE(iWE), .iAddr(iAddr), .iData(iData),
    .oFiltIn(oFiltIn), .oOut(oOut), .oValid(oValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic [15:0] filt;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int off(input int vol);
`ifdef MIXER_DIGI_EN
    return vol * 512;
`else
    return 0 * vol;
`endif
  endfunction

  // Monitor: every oValid pulse must match the oldest expected sample.
  always @(negedge clk) begin
    if (oValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        got = sb.pop_front();
        check("oOut", $signed(oOut), $signed(got.out));
        check("oFiltIn", $signed(oFiltIn), $signed(got.filt));
        check("latency", cyc, got.due);
      end
    end
  end

  task automatic wrReg(input logic [4:0] a, input logic [7:0] d);
    iWE = 1'b1; iAddr = a; iData = d;
    @(negedge clk);
    iWE = 1'b0;
  endtask

  task automatic setIn(input int v0, input int v1, input int v2, input int lp, input int bp, input int hp);
    iVoice0 = 16'(v0); iVoice1 = 16'(v1); iVoice2 = 16'(v2);
    iLP = 16'(lp); iBP = 16'(bp); iHP = 16'(hp);
  endtask

  task automatic pushExp(input int eOut, input int eFilt);
    exp_t e;
    e.out  = 16'(eOut);
    e.filt = 16'(eFilt);
    e.due  = cyc + 8;
    sb.push_back(e);
  endtask

  task automatic sample(input int eOut, input int eFilt);
    pushExp(eOut, eFilt);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; clkEn = 1'b0; iWE = 1'b0; iAddr = '0; iData = '0;
    setIn(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_oOut", oOut, 0);
    check("reset_oFiltIn", oFiltIn, 0);
    check("reset_oValid", oValid, 0);

    wrReg(5'h17, 8'h00); wrReg(5'h18, 8'h0F);
    setIn(1000, 1000, 1000, 0, 0, 0);
    sample(2812 + off(15), 0);

    wrReg(5'h17, 8'h07);
    setIn(20000, 20000, 20000, 0, 0, 0);
    sample(0 + off(15), 32767);

    wrReg(5'h18, 8'h00);
    setIn(-20000, -20000, -20000, 0, 0, 0);
    sample(0, -32768);

    wrReg(5'h17, 8'h00); wrReg(5'h18, 8'h8F);
    setIn(0, 0, 8000, 0, 0, 0);
    sample(0 + off(15), 0);
    wrReg(5'h17, 8'h04);
    sample(0 + off(15), 8000);

    wrReg(5'h17, 8'h00); wrReg(5'h18, 8'h18);
    setIn(0, 0, 0, -16000, 0, 0);
    sample(-8000 + off(8), 0);
    wrReg(5'h18, 8'h1F);
    setIn(0, 0, 0, -32768, 0, 0);
    sample(-30720 + off(15), 0);

    wrReg(5'h18, 8'h6F);
    setIn(100, 200, 300, 5000, 1600, -3200);
    sample(-938 + off(15), 0);

    wrReg(5'h17, 8'h05); wrReg(5'h18, 8'h0F);
    setIn(1000, 2000, -3000, 0, 0, 0);
    sample(1875 + off(15), -2000);

    // Second clkEn at cycle 3 must be ignored.
    wrReg(5'h17, 8'h00);
    setIn(1000, 1000, 1000, 0, 0, 0);
    pushExp(2812 + off(15), 0);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    setIn(3000, 3000, 3000, 0, 0, 0);
    repeat (2) @(negedge clk);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    repeat (12) @(negedge clk);

    // Reset at cycle 4 aborts the sample with no oValid.
    wrReg(5'h17, 8'h07);
    setIn(5000, 5000, 5000, 0, 0, 0);
    clkEn = 1'b1;
    @(negedge clk);
    clkEn = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_oOut", oOut, 0);
    check("abort_oFiltIn", oFiltIn, 0);
    check("abort_oValid", oValid, 0);
    repeat (12) @(negedge clk);

    setIn(1000, 1000, 1000, 0, 0, 0);
    sample(0, 0);
    wrReg(5'h18, 8'h0F);
    sample(2812 + off(15), 0);

    setIn(0, 0, 0, 0, 0, 0);
    wrReg(5'h17, 8'h00); wrReg(5'h18, 8'h0F);
    sample(off(15), 0);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sid_mixer.md
# sid_mixer

Output mixer and filter router for the SID core. Splits the three voice samples into a filter-routed sum that drives the filter input and a direct sum that bypasses it. It then combines the direct sum with the mode-selected filter outputs (LP/BP/HP), applies the 4-bit master volume and produces the final 16-bit sample. It sits between the voice generators and the filter on the input side, and between the filter and the audio output/DAC on the output side. It decodes registers 0x17 and 0x18 from the shared bus.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- clkEn  in  1  sample strobe, one cycle per SID sample; same strobe as the filter
- iVoice0, iVoice1, iVoice2  in  16 each  signed voice samples
- iLP, iBP, iHP  in  16 each  signed filter outputs
- iWE  in  1  register write strobe
- iAddr  in  5  register address
- iData  in  8  register data
- oFiltIn  out  16  signed, clipped sum of filter-routed voices; drives the filter input
- oOut  out  16  signed final mixed sample
- oValid  out  1  one-cycle pulse when oOut updates

## Operation
- Register 0x17 write: regRoute <= iData[2:0]. Bit n routes voice n to the filter. Bits [7:3] are ignored; resonance is decoded in the filter.
- Register 0x18 write: regVol <= iData[3:0], regLP <= iData[4], regBP <= iData[5], regHP <= iData[6], reg3Off <= iData[7].
- Writes take effect on the next cycle. A write during a computation does not disturb it, because operands are latched at clkEn.
- On clkEn, the block latches all six audio inputs and the register set into operand registers.
- FSM states: IDLE, SUM, MIX, VOL (4 cycles, bit counter 0..3), OUT.
  - IDLE → SUM on clkEn.
  - SUM → MIX.
  - MIX → VOL.
  - VOL → OUT after 4 iterations.
  - OUT → IDLE.
- A clkEn outside IDLE is ignored. The clkEn period must be ≥ 8 cycles.
- SUM:
  - fsum = sum of routed voices, 18-bit signed.
  - dsum = sum of unrouted voices, 18-bit signed.
  - Voice 2 is excluded from dsum when reg3Off=1 and route[2]=0.
  - A routed voice is never muted by 3OFF.
  - oFiltIn <= clip16(fsum).
- MIX: mix = dsum + (LP?iLP:0) + (BP?iBP:0) + (HP?iHP:0), 19-bit signed.
- VOL: shift-add multiply acc += (mix << k) when regVol[k], for k = 0..3. acc is 23-bit signed.
- OUT:
  - oOut <= clip16(acc >>> 4), arithmetic shift.
  - oValid = 1 for this cycle.
- clip16: saturate to [-32768, 32767].
- Volume 15 yields 15/16 gain. Volume 0 yields 0 unless MIXER_DIGI_EN is defined.
- Reset mid-computation: FSM → IDLE, acc cleared, no oValid pulse for the aborted sample.

## Timing
- The clkEn edge is cycle 0.
- oFiltIn is updated at cycle 1 and holds until the next sample's SUM. The filter samples its input at its state 3, which is cycle 4, so it sees the current frame.
- oOut and oValid update at cycle 7 (states SUM 1, MIX 2, VOL 3–6, OUT 7).
- Filter outputs are latched at cycle 0, so oOut carries the filter response from the previous frame: a fixed one-sample delay on the filtered path.
- Reset values:
  - oFiltIn = 0, oOut = 0, oValid = 0.
  - All registers = 0, FSM = IDLE.

## Configuration
- MIXER_DIGI_EN defined: OUT adds a DC offset of signed (regVol << 9) to acc >>> 4 before clipping. This models the 6581 volume-register DC step used for sample playback, so a 0x18 write is audible with all voices silent.
- Undefined: no offset; silent voices give oOut = 0 at any volume.

## Structure
- A shared sid_pkg holds:
  - register address constants: ADDR_RES_FILT = 5'h17, ADDR_MODE_VOL = 5'h18;
  - the FSM state enum;
  - the clip16 function, shared with the filter clipper.
- One natural sub-module, sid_mixer_vol: the 4-cycle shift-add volume multiplier, with start/done handshake.

## Test plan
- Reset, then clkEn with all voices = 1000, route = 0, vol = 15 → oValid at cycle 7, oOut = 2812 (3000 × 15 / 16), oFiltIn = 0.
- Route = 3'b111, voices = 20000 each → oFiltIn = 32767 (saturated). With LP=BP=HP=0, oOut = 0.
- reg3Off = 1, route = 0, voice2 = 8000, others 0, vol = 15 → oOut = 0. Set route[2] = 1 → oFiltIn = 8000.
- vol = 8, LP = 1, iLP = -16000, dsum = 0 → oOut = -8000. With iLP = -32768 and vol = 15 → oOut = -30720.
- A second clkEn at cycle 3 is ignored. Asserting rst at cycle 4 gives no oValid, oOut stays at its prior value… except after reset, where oOut = 0. The next clkEn completes normally.
- MIXER_DIGI_EN defined, voices = 0, write 0x18 = 0x0F → oOut = 7680. Undefined → 0.
